// File: rtl/loop_activity_recorder_pkg.sv
// Shared types and helpers for the per-loop activity recorder.
package loop_rec_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        CLOSED
    } state_t;

    localparam int unsigned CNT_W_DEF = 32;
    localparam int unsigned ID_W_DEF  = 4;
    // Widest counter the saturating helper supports.
    localparam int unsigned CNT_MAX   = 64;

    localparam int unsigned FLAG_TRUNC = 0;
    localparam int unsigned FLAG_SAT   = 1;

    typedef struct packed {
        logic [ID_W_DEF-1:0]  loop_id;
        logic [CNT_W_DEF-1:0] start_ts;
        logic [CNT_W_DEF-1:0] latency;
        logic [CNT_W_DEF-1:0] iters;
        logic [CNT_W_DEF-1:0] stalls;
        logic [1:0]           flags;
    } loop_rec_t;

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [CNT_MAX-1:0] sat_inc(input logic [CNT_MAX-1:0] v,
                                                   input int unsigned w);
        logic [CNT_MAX-1:0] lim;
        lim = {CNT_MAX{1'b1}} >> (CNT_MAX - w);
        return (v >= lim) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/loop_activity_recorder_if.sv
// Record stream from the recorder to the status-dump collector.
interface loop_activity_recorder_if #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned ID_W  = 4
);
    logic             rec_valid;
    logic             rec_ready;
    logic [ID_W-1:0]  rec_loop_id;
    logic [CNT_W-1:0] rec_start_ts;
    logic [CNT_W-1:0] rec_latency;
    logic [CNT_W-1:0] rec_iters;
    logic [CNT_W-1:0] rec_stalls;
    logic [1:0]       rec_flags;

    modport master (
        output rec_valid, rec_loop_id, rec_start_ts, rec_latency,
               rec_iters, rec_stalls, rec_flags,
        input  rec_ready
    );

    modport slave (
        input  rec_valid, rec_loop_id, rec_start_ts, rec_latency,
               rec_iters, rec_stalls, rec_flags,
        output rec_ready
    );
endinterface

// File: rtl/loop_activity_recorder_rec_fifo.sv
// Small synchronous first-word-fall-through FIFO of activity records.
module rec_fifo
    import loop_rec_pkg::*;
#(
    parameter type         T     = loop_rec_t,
    parameter int unsigned DEPTH = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic push,
    input  T     din,
    input  logic pop,
    output T     dout,
    output logic full,
    output logic empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage write; contents are only observable through the head pointer.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/loop_activity_recorder.sv
// Observes one pipelined loop's handshake and emits one record per invocation.
module loop_activity_recorder
    import loop_rec_pkg::*;
#(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned ID_W       = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ID_W-1:0]       loop_id,
    input  logic                  loop_start,
    input  logic                  loop_done,
    input  logic                  iter_end,
    input  logic                  stall,
    input  logic                  finish,
    loop_activity_recorder_if.master rec,
    output logic [CNT_W-1:0]      drop_count,
    output logic                  busy
);
    typedef struct packed {
        logic [ID_W-1:0]  loop_id;
        logic [CNT_W-1:0] start_ts;
        logic [CNT_W-1:0] latency;
        logic [CNT_W-1:0] iters;
        logic [CNT_W-1:0] stalls;
        logic [1:0]       flags;
    } rec_t;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v, input logic en);
        logic [CNT_MAX-1:0] w;
        w = sat_inc(CNT_MAX'(v), CNT_W);
        return en ? w[CNT_W-1:0] : v;
    endfunction

    state_t           state, state_nxt;
    logic [CNT_W-1:0] ts, start_ts, lat, iters, stalls;
    logic [CNT_W-1:0] start_ts_nxt, lat_nxt, iters_nxt, stalls_nxt;
    logic             sat, sat_nxt;
    logic [CNT_W-1:0] lat_inc, iters_inc, stalls_inc;
    logic             sat_acc;
    logic             push_req, push_ok, pop, full, empty;
    rec_t             push_rec, head;

    assign busy    = (state == ACTIVE);
    assign pop     = rec.rec_valid & rec.rec_ready;
    assign push_ok = push_req & (~full | pop);

    assign rec.rec_valid    = ~empty;
    assign rec.rec_loop_id  = head.loop_id;
    assign rec.rec_start_ts = head.start_ts;
    assign rec.rec_latency  = head.latency;
    assign rec.rec_iters    = head.iters;
    assign rec.rec_stalls   = head.stalls;
    assign rec.rec_flags    = head.flags;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state, counter update and record assembly.
    always_comb begin
        lat_inc    = bump(lat, 1'b1);
        iters_inc  = bump(iters, iter_end);
        stalls_inc = bump(stalls, stall);
        sat_acc    = sat | (&lat) | (iter_end & (&iters)) | (stall & (&stalls));

        state_nxt        = state;
        start_ts_nxt     = start_ts;
        lat_nxt          = lat;
        iters_nxt        = iters;
        stalls_nxt       = stalls;
        sat_nxt          = sat;
        push_req         = 1'b0;
        push_rec         = '0;
        push_rec.loop_id = loop_id;

        case (state)
            IDLE: begin
                if (loop_start && loop_done) begin
                    push_req          = 1'b1;
                    push_rec.start_ts = ts;
                    push_rec.latency  = CNT_W'(1);
                    push_rec.iters    = CNT_W'(iter_end);
                    push_rec.stalls   = CNT_W'(stall);
                    if (finish) state_nxt = CLOSED;
                end else if (finish) begin
                    state_nxt = CLOSED;
                end else if (loop_start) begin
                    state_nxt    = ACTIVE;
                    start_ts_nxt = ts;
                    lat_nxt      = CNT_W'(1);
                    iters_nxt    = '0;
                    stalls_nxt   = '0;
                    sat_nxt      = 1'b0;
                end
            end
            ACTIVE: begin
                if (loop_done || finish) begin
                    // Done wins over finish: truncation only flagged without done.
                    push_req                    = 1'b1;
                    push_rec.start_ts           = start_ts;
                    push_rec.latency            = lat_inc;
                    push_rec.iters              = iters_inc;
                    push_rec.stalls             = stalls_inc;
                    push_rec.flags[FLAG_SAT]    = sat_acc;
                    push_rec.flags[FLAG_TRUNC]  = ~loop_done;
                    if (finish) begin
                        state_nxt = CLOSED;
                    end else if (!loop_start) begin
                        state_nxt = IDLE;
                    end else begin
                        start_ts_nxt = ts;
                        lat_nxt      = CNT_W'(1);
                        iters_nxt    = '0;
                        stalls_nxt   = '0;
                        sat_nxt      = 1'b0;
                    end
                end else begin
                    lat_nxt    = lat_inc;
                    iters_nxt  = iters_inc;
                    stalls_nxt = stalls_inc;
                    sat_nxt    = sat_acc;
                end
            end
            CLOSED: begin
                state_nxt = CLOSED;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Timestamp, invocation counters and drop counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            ts         <= '0;
            start_ts   <= '0;
            lat        <= '0;
            iters      <= '0;
            stalls     <= '0;
            sat        <= 1'b0;
            drop_count <= '0;
        end else begin
            ts         <= bump(ts, 1'b1);
            start_ts   <= start_ts_nxt;
            lat        <= lat_nxt;
            iters      <= iters_nxt;
            stalls     <= stalls_nxt;
            sat        <= sat_nxt;
            drop_count <= bump(drop_count, push_req & ~push_ok);
        end
    end

    rec_fifo #(
        .T     (rec_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_ok),
        .din   (push_rec),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_loop_activity_recorder.sv
// Directed bench for loop_activity_recorder: vector table plus corner sequences.
module tb_loop_activity_recorder;

    typedef struct {
        int rst, ts, st, dn, it, sl, fn;
        int ev, eb, ets, elat, eit, esl, efl;
    } vec_t;

    typedef struct {
        int st, lat, it, sl, fl;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset, start, done, iter, stl, fin;
    logic [3:0]  lid = 4'hA;
    logic [31:0] drop;
    logic        busy;

    logic        s_reset, s_start, s_done, s_iter, s_stall, s_fin;
    logic [3:0]  s_lid = 4'h3;
    logic [3:0]  s_drop;
    logic        s_busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    vec_t tbl [28];
    exp_t q [$];

    always #5 clock = ~clock;

    loop_activity_recorder_if #(.CNT_W(32), .ID_W(4)) bif ();
    loop_activity_recorder_if #(.CNT_W(4),  .ID_W(4)) sif ();

    loop_activity_recorder #(.CNT_W(32), .ID_W(4), .FIFO_DEPTH(4)) dut (
        .clock(clock), .reset(reset), .loop_id(lid), .loop_start(start),
        .loop_done(done), .iter_end(iter), .stall(stl), .finish(fin),
        .rec(bif), .drop_count(drop), .busy(busy)
    );

    loop_activity_recorder #(.CNT_W(4), .ID_W(4), .FIFO_DEPTH(4)) dut_small (
        .clock(clock), .reset(s_reset), .loop_id(s_lid), .loop_start(s_start),
        .loop_done(s_done), .iter_end(s_iter), .stall(s_stall), .finish(s_fin),
        .rec(sif), .drop_count(s_drop), .busy(s_busy)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_head(input string nm, input exp_t e);
        check({nm, ".id"},  bif.rec_loop_id,  4'hA);
        check({nm, ".ts"},  bif.rec_start_ts, e.st);
        check({nm, ".lat"}, bif.rec_latency,  e.lat);
        check({nm, ".it"},  bif.rec_iters,    e.it);
        check({nm, ".sl"},  bif.rec_stalls,   e.sl);
        check({nm, ".fl"},  bif.rec_flags,    e.fl);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic clr();
        start = 1'b0; done = 1'b0; iter = 1'b0; stl = 1'b0; fin = 1'b0;
    endtask

    task automatic do_reset();
        clr();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        vec_t v;

        // rst ts st dn it sl fn | ev eb ets elat eit esl efl
        tbl[0]  = '{1, 10, 1,0,0,0,0, 0,1,  0,0,0,0,0};
        tbl[1]  = '{0, 11, 0,0,1,0,0, 0,1,  0,0,0,0,0};
        tbl[2]  = '{0, 12, 0,0,1,0,0, 0,1,  0,0,0,0,0};
        tbl[3]  = '{0, 13, 0,0,0,1,0, 0,1,  0,0,0,0,0};
        tbl[4]  = '{0, 14, 0,0,1,0,0, 0,1,  0,0,0,0,0};
        tbl[5]  = '{0, 15, 0,0,1,0,0, 0,1,  0,0,0,0,0};
        tbl[6]  = '{0, 16, 0,0,0,1,0, 0,1,  0,0,0,0,0};
        tbl[7]  = '{0, 17, 0,1,1,0,0, 1,0, 10,8,5,2,0};
        tbl[8]  = '{0, 18, 0,0,0,0,0, 0,0,  0,0,0,0,0};
        tbl[9]  = '{1, 15, 1,0,0,0,0, 0,1,  0,0,0,0,0};
        tbl[10] = '{0, 20, 1,1,0,0,0, 1,1, 15,6,0,0,0};
        tbl[11] = '{0, 21, 0,0,0,0,0, 0,1,  0,0,0,0,0};
        tbl[12] = '{0, 22, 0,1,0,0,0, 1,0, 20,3,0,0,0};
        tbl[13] = '{0, 23, 0,0,0,0,0, 0,0,  0,0,0,0,0};
        tbl[14] = '{0, 25, 1,1,1,1,0, 1,0, 25,1,1,1,0};
        tbl[15] = '{0, 26, 0,0,0,0,0, 0,0,  0,0,0,0,0};
        tbl[16] = '{1,  5, 1,0,0,0,0, 0,1,  0,0,0,0,0};
        tbl[17] = '{0,  9, 0,0,1,0,1, 1,0,  5,5,1,0,1};
        tbl[18] = '{0, 10, 0,0,0,0,0, 0,0,  0,0,0,0,0};
        tbl[19] = '{0, 12, 1,0,0,0,0, 0,0,  0,0,0,0,0};
        tbl[20] = '{0, 13, 0,1,0,0,0, 0,0,  0,0,0,0,0};
        tbl[21] = '{1,  3, 1,0,0,0,0, 0,1,  0,0,0,0,0};
        tbl[22] = '{0,  6, 0,1,0,1,1, 1,0,  3,4,0,1,0};
        tbl[23] = '{0,  7, 1,0,0,0,0, 0,0,  0,0,0,0,0};
        tbl[24] = '{0,  8, 1,1,0,0,0, 0,0,  0,0,0,0,0};
        tbl[25] = '{1,  2, 0,0,0,0,1, 0,0,  0,0,0,0,0};
        tbl[26] = '{0,  4, 1,0,0,0,0, 0,0,  0,0,0,0,0};
        tbl[27] = '{0,  5, 1,1,0,0,0, 0,0,  0,0,0,0,0};

        s_reset = 1'b1; s_start = 1'b0; s_done = 1'b0; s_iter = 1'b0;
        s_stall = 1'b0; s_fin = 1'b0; sif.rec_ready = 1'b1;
        bif.rec_ready = 1'b1;

        // Reset state
        do_reset();
        check("rst.valid", bif.rec_valid, 0);
        check("rst.busy",  busy, 0);
        check("rst.drop",  drop, 0);
        check("rst.ts",    bif.rec_start_ts, 0);
        check("rst.lat",   bif.rec_latency, 0);

        // Table-driven vectors
        for (int i = 0; i < 28; i++) begin
            v = tbl[i];
            if (v.rst != 0) do_reset();
            bif.rec_ready = 1'b1;
            while (cyc < v.ts) tick();
            start = v.st[0]; done = v.dn[0]; iter = v.it[0];
            stl = v.sl[0]; fin = v.fn[0];
            tick();
            clr();
            check($sformatf("row%0d.valid", i), bif.rec_valid, v.ev);
            check($sformatf("row%0d.busy", i),  busy, v.eb);
            if (v.ev != 0) begin
                e = '{v.ets, v.elat, v.eit, v.esl, v.efl};
                check_head($sformatf("row%0d", i), e);
            end
        end

        // Backpressure: six invocations into a four-deep FIFO
        do_reset();
        bif.rec_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            int st;
            st = cyc;
            start = 1'b1;
            tick();
            start = 1'b0; done = 1'b1; iter = k[0];
            tick();
            clr();
            tick();
            if (k < 4) q.push_back('{st, 2, k % 2, 0, 0});
        end
        check("bp.drop",  drop, 2);
        check("bp.valid", bif.rec_valid, 1);
        for (int h = 0; h < 3; h++) begin
            check_head($sformatf("bp.hold%0d", h), q[0]);
            tick();
        end
        // Drain while pushing into the still-full FIFO in the same cycle
        bif.rec_ready = 1'b1;
        start = 1'b1; done = 1'b1; iter = 1'b1;
        q.push_back('{cyc, 1, 1, 0, 0});
        check_head("bp.drain0", q.pop_front());
        tick();
        clr();
        for (int j = 1; j < 9 && q.size() > 0; j++) begin
            check($sformatf("bp.valid%0d", j), bif.rec_valid, 1);
            check_head($sformatf("bp.drain%0d", j), q.pop_front());
            tick();
        end
        check("bp.empty", bif.rec_valid, 0);
        check("bp.drop2", drop, 2);

        // Reset with queued records and an open invocation
        do_reset();
        bif.rec_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            start = 1'b1; done = 1'b1;
            tick();
            clr();
        end
        start = 1'b1;
        tick();
        clr();
        check("mr.busy",  busy, 1);
        check("mr.valid", bif.rec_valid, 1);
        check("mr.drop",  drop, 1);
        reset = 1'b1; done = 1'b1;
        tick();
        check("mr.valid_rst", bif.rec_valid, 0);
        check("mr.busy_rst",  busy, 0);
        check("mr.drop_rst",  drop, 0);
        check("mr.lat_rst",   bif.rec_latency, 0);
        reset = 1'b0; done = 1'b0; bif.rec_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("mr.valid_after%0d", k), bif.rec_valid, 0);
            check($sformatf("mr.busy_after%0d", k),  busy, 0);
        end

        // Saturation on the 4-bit instance
        tick();
        s_reset = 1'b0;
        tick();
        tick();
        s_start = 1'b1;
        tick();
        s_start = 1'b0; s_iter = 1'b1;
        repeat (19) tick();
        s_done = 1'b1;
        tick();
        s_done = 1'b0; s_iter = 1'b0;
        check("sat.valid", sif.rec_valid, 1);
        check("sat.id",    sif.rec_loop_id, 4'h3);
        check("sat.ts",    sif.rec_start_ts, 2);
        check("sat.lat",   sif.rec_latency, 15);
        check("sat.it",    sif.rec_iters, 15);
        check("sat.sl",    sif.rec_stalls, 0);
        check("sat.fl",    sif.rec_flags, 2);
        check("sat.busy",  s_busy, 0);
        tick();
        s_start = 1'b1; s_done = 1'b1;
        tick();
        s_start = 1'b0; s_done = 1'b0;
        check("satts.valid", sif.rec_valid, 1);
        check("satts.ts",    sif.rec_start_ts, 15);
        check("satts.lat",   sif.rec_latency, 1);
        check("satts.fl",    sif.rec_flags, 0);
        check("satts.drop",  s_drop, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
